// File: rtl/mario_sprite_drawer.sv
`default_nettype none
// ============================================================================
//  Module      : mario_sprite_drawer
//  Description : Composites an animated, optionally mirrored Mario sprite
//                over a background pixel stream. A two-stage pipeline
//                addresses the external sprite ROM and applies the colour
//                key. A frame-tick driven FSM selects the ROM bank
//                (stand / walk1-4 / jump).
//  Revision    : 1.0 - initial release
// ============================================================================
module mario_sprite_drawer #(
  parameter int          SPR_W     = 20,
  parameter int          SPR_H     = 22,
  parameter int          FRAME_DIV = 6,
  parameter logic [11:0] KEY_COLOR = 12'h808
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [11:0] bg_color,
  input  logic [9:0]  mario_x,
  input  logic [9:0]  mario_y,
  input  logic        walking,
  input  logic        facing_left,
  input  logic        airborne,
  output logic [8:0]  read_address,
  output logic [2:0]  frame_sel,
  input  logic [11:0] sprite_color,
  output logic [11:0] pixel_color,
  output logic        sprite_hit
);

  // Step counter must hold 0..FRAME_DIV-1; keep at least one bit.
  localparam int c_CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  typedef enum logic [2:0] {
    STAND = 3'd0,
    WALK1 = 3'd1,
    WALK2 = 3'd2,
    WALK3 = 3'd3,
    WALK4 = 3'd4,
    JUMP  = 3'd5
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_step;
  logic               r_face_left;

  logic               r_inbox1;
  logic [11:0]        r_bg1;

  logic               w_in_x;
  logic               w_in_y;
  logic               w_inbox;
  logic [9:0]         w_col;
  logic [9:0]         w_col_m;
  logic [9:0]         w_row;
  logic [8:0]         w_addr;
  logic               w_opaque;

  // Box test in 11 bits so a sprite straddling column/row 1023 never wraps.
  always_comb begin
    w_in_x  = ({1'b0, DrawX} >= {1'b0, mario_x}) &&
              ({1'b0, DrawX} <  ({1'b0, mario_x} + 11'(SPR_W)));
    w_in_y  = ({1'b0, DrawY} >= {1'b0, mario_y}) &&
              ({1'b0, DrawY} <  ({1'b0, mario_y} + 11'(SPR_H)));
    w_inbox = w_in_x && w_in_y;
    w_col   = DrawX - mario_x;
    w_row   = DrawY - mario_y;
    // Mirroring uses the direction latched at the last frame tick only.
    w_col_m = r_face_left ? (10'(SPR_W - 1) - w_col) : w_col;
    w_addr  = 9'(w_row) * 9'(SPR_W) + 9'(w_col_m);
  end

  // Stage 1: sprite ROM address, in-box flag and aligned background colour.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_address <= 9'd0;
      r_inbox1     <= 1'b0;
      r_bg1        <= 12'h000;
    end else begin
      read_address <= w_inbox ? w_addr : 9'd0;
      r_inbox1     <= w_inbox;
      r_bg1        <= bg_color;
    end
  end

  // The ROM answers combinationally, so the key test lands in stage 2.
  always_comb begin
    w_opaque = r_inbox1 && (sprite_color != KEY_COLOR);
  end

  // Stage 2: choose sprite or background colour and flag opaque hits.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pixel_color <= 12'h000;
      sprite_hit  <= 1'b0;
    end else begin
      pixel_color <= w_opaque ? sprite_color : r_bg1;
      sprite_hit  <= w_opaque;
    end
  end

  // Animation FSM: advances only on frame ticks so banks never swap mid-frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= STAND;
      r_step      <= '0;
      r_face_left <= 1'b0;
      frame_sel   <= 3'd0;
    end else if (frame_tick) begin
      r_face_left <= facing_left;
      if (airborne) begin
        r_state   <= JUMP;
        r_step    <= '0;
        frame_sel <= 3'd5;
      end else if (!walking) begin
        r_state   <= STAND;
        r_step    <= '0;
        frame_sel <= 3'd0;
      end else begin
        case (r_state)
          WALK1, WALK2, WALK3, WALK4: begin
            if (r_step == c_CNT_W'(FRAME_DIV - 1)) begin
              r_step <= '0;
              case (r_state)
                WALK1:   begin r_state <= WALK2; frame_sel <= 3'd2; end
                WALK2:   begin r_state <= WALK3; frame_sel <= 3'd3; end
                WALK3:   begin r_state <= WALK4; frame_sel <= 3'd4; end
                default: begin r_state <= WALK1; frame_sel <= 3'd1; end
              endcase
            end else begin
              r_step <= r_step + 1'b1;
            end
          end
          default: begin
            // From STAND or JUMP the walk cycle restarts at its first pose.
            r_state   <= WALK1;
            r_step    <= '0;
            frame_sel <= 3'd1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mario_sprite_drawer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mario_sprite_drawer
//  Description : Directed self-checking bench for mario_sprite_drawer. The
//                sprite ROM is modelled as {frame_sel, read_address}, with
//                an override that returns the colour key.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mario_sprite_drawer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_tick;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [11:0] bg_color;
  logic [9:0]  mario_x;
  logic [9:0]  mario_y;
  logic        walking;
  logic        facing_left;
  logic        airborne;
  logic [8:0]  read_address;
  logic [2:0]  frame_sel;
  logic [11:0] sprite_color;
  logic [11:0] pixel_color;
  logic        sprite_hit;
  logic        force_key;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  // Sprite ROM stand-in: the colour encodes the bank and the address.
  assign sprite_color = force_key ? 12'h808 : {frame_sel, read_address};

  mario_sprite_drawer dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_tick   (frame_tick),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .bg_color     (bg_color),
    .mario_x      (mario_x),
    .mario_y      (mario_y),
    .walking      (walking),
    .facing_left  (facing_left),
    .airborne     (airborne),
    .read_address (read_address),
    .frame_sel    (frame_sel),
    .sprite_color (sprite_color),
    .pixel_color  (pixel_color),
    .sprite_hit   (sprite_hit)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  initial begin
    Reset_n     = 1'b0;
    frame_tick  = 1'b0;
    DrawX       = 10'd0;
    DrawY       = 10'd0;
    bg_color    = 12'h27B;
    mario_x     = 10'd100;
    mario_y     = 10'd50;
    walking     = 1'b0;
    facing_left = 1'b0;
    airborne    = 1'b0;
    force_key   = 1'b0;

    // Reset values
    #3;
    chk("rst_addr",  12'(read_address), 12'h000);
    chk("rst_sel",   12'(frame_sel),    12'h000);
    chk("rst_pix",   pixel_color,       12'h000);
    chk("rst_hit",   12'(sprite_hit),   12'h000);
    cyc();
    Reset_n = 1'b1;

    // Right-facing in-box pixel: row 2, col 5 -> 45
    DrawX = 10'd105; DrawY = 10'd52;
    cyc();
    chk("addr_right", 12'(read_address), 12'd45);
    cyc();
    chk("pix_right", pixel_color, 12'h02D);
    chk("hit_right", 12'(sprite_hit), 12'h001);

    // Key colour inside box shows background
    force_key = 1'b1;
    cyc();
    cyc();
    chk("pix_key", pixel_color, 12'h27B);
    chk("hit_key", 12'(sprite_hit), 12'h000);
    force_key = 1'b0;

    // Left of box: address 0, background passes through
    DrawX = 10'd99; bg_color = 12'h1A5;
    cyc();
    chk("addr_out", 12'(read_address), 12'h000);
    cyc();
    chk("pix_out", pixel_color, 12'h1A5);
    chk("hit_out", 12'(sprite_hit), 12'h000);

    // Direction is not taken until a frame tick
    DrawX = 10'd105; facing_left = 1'b1;
    cyc();
    chk("addr_nolatch", 12'(read_address), 12'd45);
    tick();
    cyc();
    chk("addr_left", 12'(read_address), 12'd54);
    cyc();
    chk("pix_left", pixel_color, 12'h036);
    chk("hit_left", 12'(sprite_hit), 12'h001);
    chk("sel_stand", 12'(frame_sel), 12'h000);

    // Walk cycle with FRAME_DIV=6
    facing_left = 1'b0;
    walking = 1'b1;
    for (int t = 1; t <= 25; t++) begin
      tick();
      if (t == 1)  chk("walk_t1",  12'(frame_sel), 12'd1);
      if (t == 6)  chk("walk_t6",  12'(frame_sel), 12'd1);
      if (t == 7)  chk("walk_t7",  12'(frame_sel), 12'd2);
      if (t == 13) chk("walk_t13", 12'(frame_sel), 12'd3);
      if (t == 19) chk("walk_t19", 12'(frame_sel), 12'd4);
      if (t == 25) chk("walk_t25", 12'(frame_sel), 12'd1);
    end
    // No change without a tick
    cyc(); cyc();
    chk("walk_hold", 12'(frame_sel), 12'd1);
    for (int t = 26; t <= 37; t++) tick();
    chk("walk3", 12'(frame_sel), 12'd3);

    // Jump wins over walking, then back to WALK1, then stand
    airborne = 1'b1;
    tick();
    chk("jump", 12'(frame_sel), 12'd5);
    airborne = 1'b0;
    tick();
    chk("jump_to_walk1", 12'(frame_sel), 12'd1);
    walking = 1'b0;
    tick();
    chk("to_stand", 12'(frame_sel), 12'd0);

    // Right screen edge, with a tick arriving alongside in-box pixels
    mario_x = 10'd1015; DrawX = 10'd1020; DrawY = 10'd50; bg_color = 12'h3C4;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chk("addr_edge", 12'(read_address), 12'd5);
    cyc();
    chk("pix_edge", pixel_color, 12'h005);
    chk("hit_edge", 12'(sprite_hit), 12'h001);
    DrawX = 10'd3;
    cyc();
    chk("addr_nowrap", 12'(read_address), 12'h000);
    cyc();
    chk("pix_nowrap", pixel_color, 12'h3C4);
    chk("hit_nowrap", 12'(sprite_hit), 12'h000);

    // Mid-line asynchronous reset
    walking = 1'b1;
    tick();
    DrawX = 10'd1020;
    cyc();
    cyc();
    chk("pix_prerst", pixel_color, 12'h205);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("mrst_addr", 12'(read_address), 12'h000);
    chk("mrst_sel",  12'(frame_sel),    12'h000);
    chk("mrst_pix",  pixel_color,       12'h000);
    chk("mrst_hit",  12'(sprite_hit),   12'h000);
    cyc();
    chk("mrst_hold", pixel_color, 12'h000);
    walking = 1'b0;
    Reset_n = 1'b1;
    cyc();
    chk("resume_addr", 12'(read_address), 12'd5);
    chk("resume_pix1", pixel_color, 12'h000);
    cyc();
    chk("resume_pix2", pixel_color, 12'h005);
    chk("resume_hit",  12'(sprite_hit), 12'h001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
